fb_wr_arbiter: RTL and testbench
================================

Name: fb_wr_arbiter

Overview:
Owns the single write port of the 12bpp panel framebuffer (two 12-bit pixels per 24-bit word: top half-screen in [23:12], bottom half in [11:0]). Shares the port between the PS/2 mouse paint path (valid/ready pixel writes) and an internal clear/fill engine that floods the whole screen with one colour. The panel refresh side only reads, so it is not arbitrated here.

Parameters:
NUM_COLS, 64, panel columns; x width XW = clog2(NUM_COLS) = 6
NUM_ROWS, 64, panel rows; y width YW = clog2(NUM_ROWS) = 6
BIT_DEPTH, 4, bits per colour channel; pixel width PW = 3*BIT_DEPTH = 12
Derived: word address width AW = XW+YW-1 = 11; word count NUM_WORDS = NUM_COLS*NUM_ROWS/2 = 2048

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
px_valid  in  1  paint request
px_ready  out  1  paint request accepted when px_valid & px_ready
px_x  in  XW  pixel column
px_y  in  YW  pixel row
px_color  in  PW  pixel colour {R,G,B}
clr_start  in  1  one-cycle pulse: start a full-screen fill
clr_color  in  PW  fill colour, sampled on the accepted clr_start
clr_busy  out  1  fill in progress
clr_done  out  1  one-cycle pulse after the last fill write
mem_we  out  1  framebuffer write strobe
mem_addr  out  AW  word address
mem_be  out  2  half enables: bit1 -> [23:12] (top), bit0 -> [11:0] (bottom)
mem_wdata  out  2*PW  write data

Behaviour:
- Reset is synchronous (rst==0 at a clk edge). All outputs are 0 after reset; the FSM goes to IDLE and the fill counter clears. Reset during CLEAR aborts the fill with no clr_done.
- Address mapping: px_y[YW-1]=0 is the top half and uses be=2'b10 with data in [23:12]. px_y[YW-1]=1 is the bottom half and uses be=2'b01 with data in [11:0]. mem_addr = {px_y[YW-2:0], px_x}. The unused half of mem_wdata is driven 0.
- All mem_* outputs are registered. An accepted request appears on mem_* exactly 1 cycle after acceptance, with mem_we high for 1 cycle. Back-to-back accepts give mem_we high on consecutive cycles.
- The FSM has three states: IDLE, CLEAR, DONE.
  - IDLE: px_ready=1. On clr_start, latch clr_color, zero the word counter, go to CLEAR.
  - CLEAR: px_ready=0, clr_busy=1. Each cycle writes word addr = counter with be=2'b11 and wdata={clr_color,clr_color}, then counter increments. When counter == NUM_WORDS-1 is issued, go to DONE. A fill takes exactly NUM_WORDS write cycles (2048).
  - DONE: one cycle. clr_done=1, clr_busy=0, px_ready=0. Then go to IDLE.
- clr_start in CLEAR or DONE is ignored (no restart, no queue).
- clr_start and px_valid in the same IDLE cycle: the paint is accepted (px_ready=1 that cycle). Its write is issued on the next cycle, and the first fill write (addr 0) follows the cycle after that. The paint pixel is therefore overwritten by the fill.
- px_valid held during CLEAR keeps px_x/px_y/px_color stable (requester rule). It is accepted in the first IDLE cycle.
- The counter never wraps: it is held at the terminal value on leaving CLEAR and cleared on the next start.

Optional Feature:
Macro FB_PAINT_INTERLEAVE_EN.
- Defined: during CLEAR, the paint path and the fill alternate round-robin. When px_valid=1 and the previous slot went to the fill, px_ready=1 and the paint write takes the slot; the fill counter stalls that cycle. A fill with P interleaved paints lasts NUM_WORDS+P write cycles. A paint whose word the fill has not yet reached is later overwritten.
- Undefined: paint is fully blocked during CLEAR and DONE, as described above.

Test Plan:
1. Reset: hold rst=0 for 3 clk with all inputs toggling -> every output 0. Release -> px_ready=1 and clr_busy=0 on the first cycle.
2. Paint top half: px_x=5, px_y=3, px_color=12'hABC, valid 1 cycle -> next cycle mem_we=1, mem_addr=11'd197, mem_be=2'b10, mem_wdata=24'hABC000. Paint bottom half: px_y=35 -> mem_addr=11'd197, mem_be=2'b01, mem_wdata=24'h000ABC.
3. Fill: clr_start with clr_color=12'h0F0 -> 2048 consecutive writes, addr 0..2047, be=2'b11, wdata=24'h0F00F0. clr_done pulses exactly 1 cycle after the write to addr 2047. clr_busy is high for exactly 2048 cycles.
4. Blocking: px_valid held from fill cycle 100 -> px_ready=0 until IDLE, then 1 accept. Without FB_PAINT_INTERLEAVE_EN there are 0 paint writes during the fill. With the macro, paint writes alternate with fill writes and the fill lasts 2048+P cycles.
5. Collisions: clr_start during CLEAR at cycle 500 -> fill not restarted, total fill writes still 2048. Simultaneous clr_start and px_valid in IDLE -> the paint write is followed next cycle by the fill write to addr 0.
6. Reset mid-fill: rst=0 at fill cycle 1000 -> mem_we=0, clr_busy=0, no clr_done. After release, a new clr_start restarts the fill at addr 0.

Source files
------------

// File: rtl/fb_wr_arbiter.sv
// rtl/fb_wr_arbiter.sv - framebuffer write-port arbiter: mouse paint path vs full-screen fill engine
// Optional build macro FB_PAINT_INTERLEAVE_EN: round-robin paint/fill slots during a fill.
module fb_wr_arbiter #(
    parameter int NUM_COLS  = 64,
    parameter int NUM_ROWS  = 64,
    parameter int BIT_DEPTH = 4,
    localparam int XW        = $clog2(NUM_COLS),
    localparam int YW        = $clog2(NUM_ROWS),
    localparam int PW        = 3 * BIT_DEPTH,
    localparam int AW        = XW + YW - 1,
    localparam int NUM_WORDS = NUM_COLS * NUM_ROWS / 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            px_valid,
    output logic            px_ready,
    input  logic [XW-1:0]   px_x,
    input  logic [YW-1:0]   px_y,
    input  logic [PW-1:0]   px_color,
    input  logic            clr_start,
    input  logic [PW-1:0]   clr_color,
    output logic            clr_busy,
    output logic            clr_done,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [1:0]      mem_be,
    output logic [2*PW-1:0] mem_wdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    r_state;
    logic [AW-1:0] r_cnt;
    logic [PW-1:0] r_clr_color;
    logic          w_accept;
    logic          w_fill_slot;

`ifdef FB_PAINT_INTERLEAVE_EN
    logic r_last_paint;

    // A paint may only take a fill-engine slot if the previous slot was the fill's.
    always_comb begin
        px_ready = rst && ((r_state == S_IDLE) || ((r_state == S_CLEAR) && !r_last_paint));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_paint <= 1'b0;
        end else begin
            r_last_paint <= w_accept;
        end
    end
`else
    always_comb begin
        px_ready = rst && (r_state == S_IDLE);
    end
`endif

    always_comb begin
        w_accept    = px_valid && px_ready;
        w_fill_slot = (r_state == S_CLEAR) && !w_accept;
        clr_busy    = (r_state == S_CLEAR);
        clr_done    = (r_state == S_DONE);
    end

    // The counter holds its terminal value after the fill; only a new start clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_clr_color <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clr_start) begin
                        r_clr_color <= clr_color;
                        r_cnt       <= '0;
                        r_state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (w_fill_slot) begin
                        if (r_cnt == AW'(NUM_WORDS - 1)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Top half-screen lives in [23:12], bottom half in [11:0] of the same word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 2'b00;
            mem_wdata <= '0;
        end else begin
            mem_we <= w_accept || w_fill_slot;
            if (w_accept) begin
                mem_addr <= {px_y[YW-2:0], px_x};
                if (px_y[YW-1]) begin
                    mem_be    <= 2'b01;
                    mem_wdata <= {{PW{1'b0}}, px_color};
                end else begin
                    mem_be    <= 2'b10;
                    mem_wdata <= {px_color, {PW{1'b0}}};
                end
            end else if (w_fill_slot) begin
                mem_addr  <= r_cnt;
                mem_be    <= 2'b11;
                mem_wdata <= {r_clr_color, r_clr_color};
            end
        end
    end

endmodule

// File: tb/tb_fb_wr_arbiter.sv
// tb/tb_fb_wr_arbiter.sv - self-checking bench for fb_wr_arbiter
module tb_fb_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        px_valid;
    logic        px_ready;
    logic [5:0]  px_x;
    logic [5:0]  px_y;
    logic [11:0] px_color;
    logic        clr_start;
    logic [11:0] clr_color;
    logic        clr_busy;
    logic        clr_done;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [1:0]  mem_be;
    logic [23:0] mem_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fb_wr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_color  (px_color),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata)
    );

    typedef struct {
        logic [5:0]  x;
        logic [5:0]  y;
        logic [11:0] c;
        logic [10:0] a;
        logic [1:0]  be;
        logic [23:0] d;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected bus image {we, addr, be, wdata} for one pixel write, from the screen geometry.
    function automatic logic [37:0] model_wr(input int x, input int y, input int c);
        int addr;
        int be;
        int data;
        addr = (y % 32) * 64 + x;
        if (y >= 32) begin
            be   = 1;
            data = c;
        end else begin
            be   = 2;
            data = c * 4096;
        end
        return {1'b1, addr[10:0], be[1:0], data[23:0]};
    endfunction

    int f_writes, f_addr_err, f_data_err, f_busy, f_first_busy, f_last_busy;
    int f_done_cnt, f_done_cyc, f_first_fill, f_paint_first, f_paint_in_fill;
    int f_acc_fill, f_post_acc, f_post_wr;

    task automatic run_fill(input logic [11:0] col, input int hold_from, input int restart_at,
                            input bit with_paint);
        bit holding;
        holding = 1'b0;
        f_writes = 0; f_addr_err = 0; f_data_err = 0; f_busy = 0; f_first_busy = -1;
        f_last_busy = -1; f_done_cnt = 0; f_done_cyc = -1; f_first_fill = -1;
        f_paint_first = -1; f_paint_in_fill = 0; f_acc_fill = 0; f_post_acc = 0; f_post_wr = 0;
        clr_start = 1'b1;
        clr_color = col;
        px_valid  = with_paint;
        px_x = 6'd7; px_y = 6'd9; px_color = 12'h321;
        tick;
        clr_start = 1'b0;
        px_valid  = 1'b0;
        clr_color = ~col;
        px_x = 6'd1; px_y = 6'd40; px_color = 12'h5A5;
        for (int n = 1; n <= 5000; n++) begin
            if (clr_busy) begin
                f_busy++;
                if (f_first_busy < 0) f_first_busy = n;
                f_last_busy = n;
            end
            if (clr_done) begin
                f_done_cnt++;
                f_done_cyc = n;
            end
            if (mem_we) begin
                if (mem_be == 2'b11) begin
                    if (f_first_fill < 0) f_first_fill = n;
                    if (int'(mem_addr) != f_writes) f_addr_err++;
                    if (mem_wdata != {col, col}) f_data_err++;
                    f_writes++;
                end else begin
                    if (f_paint_first < 0) f_paint_first = n;
                    if (f_first_busy >= 0 && n > f_first_busy && f_done_cnt == 0) f_paint_in_fill++;
                    else if (f_done_cnt > 0) f_post_wr++;
                end
            end
            clr_start = (n == restart_at);
            if (n == hold_from) holding = 1'b1;
            px_valid = holding;
            if (holding && px_ready) begin
                if (clr_busy || clr_done) f_acc_fill++;
                else begin
                    f_post_acc++;
                    holding = 1'b0;
                end
            end
            tick;
            if (f_done_cnt > 0 && n > f_done_cyc + 3) break;
        end
        clr_start = 1'b0;
        px_valid  = 1'b0;
    endtask

    initial begin
        logic [37:0] pend;
        bit          pend_v;
        int          rx, ry, rc;

        vt[0] = '{6'd5,  6'd3,  12'hABC, 11'd197,  2'b10, 24'hABC000};
        vt[1] = '{6'd5,  6'd35, 12'hABC, 11'd197,  2'b01, 24'h000ABC};
        vt[2] = '{6'd0,  6'd0,  12'hFFF, 11'd0,    2'b10, 24'hFFF000};
        vt[3] = '{6'd63, 6'd63, 12'h123, 11'd2047, 2'b01, 24'h000123};
        vt[4] = '{6'd63, 6'd31, 12'h456, 11'd2047, 2'b10, 24'h456000};
        vt[5] = '{6'd0,  6'd32, 12'h789, 11'd0,    2'b01, 24'h000789};

        rst = 1'b0;
        px_valid = 1'b0; px_x = '0; px_y = '0; px_color = '0;
        clr_start = 1'b0; clr_color = '0;

        // Reset held with inputs toggling
        for (int i = 0; i < 3; i++) begin
            px_valid  = $urandom_range(0, 1);
            clr_start = $urandom_range(0, 1);
            px_x = $urandom; px_y = $urandom; px_color = $urandom; clr_color = $urandom;
            tick;
            check("reset_outputs",
                  {px_ready, clr_busy, clr_done, mem_we, mem_addr, mem_be, mem_wdata}, 64'd0);
        end
        px_valid = 1'b0; clr_start = 1'b0;
        rst = 1'b1;
        #1;
        check("release_ready", px_ready, 1);
        check("release_busy", clr_busy, 0);
        tick;

        // Address/lane mapping table
        for (int i = 0; i < 6; i++) begin
            check("tbl_ready", px_ready, 1);
            px_valid = 1'b1; px_x = vt[i].x; px_y = vt[i].y; px_color = vt[i].c;
            tick;
            px_valid = 1'b0;
            check("tbl_write", {mem_we, mem_addr, mem_be, mem_wdata},
                  {1'b1, vt[i].a, vt[i].be, vt[i].d});
            tick;
            check("tbl_we_low", mem_we, 0);
        end

        // Randomized paint traffic against the geometry model
        pend_v = 1'b0;
        pend   = '0;
        for (int i = 0; i < 300; i++) begin
            if (pend_v) check("rand_write", {mem_we, mem_addr, mem_be, mem_wdata}, pend);
            else        check("rand_idle_we", mem_we, 0);
            rx = $urandom_range(0, 63); ry = $urandom_range(0, 63); rc = $urandom_range(0, 4095);
            px_valid = $urandom_range(0, 1);
            px_x = rx[5:0]; px_y = ry[5:0]; px_color = rc[11:0];
            pend_v = px_valid;
            if (px_valid) pend = model_wr(rx, ry, rc);
            tick;
        end
        px_valid = 1'b0;
        if (pend_v) check("rand_write", {mem_we, mem_addr, mem_be, mem_wdata}, pend);
        tick;

        // Fill with paint held from cycle 100 and a stray start at cycle 500
        run_fill(12'h0F0, 100, 500, 1'b0);
        check("fill_writes", f_writes, 2048);
        check("fill_addr_order", f_addr_err, 0);
        check("fill_data", f_data_err, 0);
        check("fill_first_busy", f_first_busy, 1);
        check("fill_first_write", f_first_fill, 2);
        check("fill_done_count", f_done_cnt, 1);
        check("fill_done_after_busy", f_done_cyc, f_last_busy + 1);
        check("fill_post_accept", f_post_acc, 1);
        check("fill_post_write", f_post_wr, 1);
`ifdef FB_PAINT_INTERLEAVE_EN
        check("fill_busy_len", f_busy, 2048 + f_paint_in_fill);
        check("fill_paint_interleaved", f_paint_in_fill > 0, 1);
        check("fill_accepts_match", f_acc_fill, f_paint_in_fill);
`else
        check("fill_busy_len", f_busy, 2048);
        check("fill_paint_blocked", f_paint_in_fill, 0);
        check("fill_ready_blocked", f_acc_fill, 0);
`endif

        // Paint and start in the same idle cycle
        run_fill(12'h00F, -1, -1, 1'b1);
        check("coll_paint_first", f_paint_first, 1);
        check("coll_fill_next", f_first_fill, 2);
        check("coll_writes", f_writes, 2048);

        // Reset in the middle of a fill
        clr_start = 1'b1; clr_color = 12'hF00;
        tick;
        clr_start = 1'b0;
        repeat (999) tick;
        check("midrst_busy_before", clr_busy, 1);
        rst = 1'b0;
        tick;
        check("midrst_outputs", {mem_we, clr_busy, clr_done, px_ready}, 0);
        rst = 1'b1;
        rx = 0;
        for (int i = 0; i < 5; i++) begin
            if (clr_done || mem_we || clr_busy) rx++;
            tick;
        end
        check("midrst_quiet", rx, 0);
        run_fill(12'h0A5, -1, -1, 1'b0);
        check("refill_writes", f_writes, 2048);
        check("refill_addr_order", f_addr_err, 0);
        check("refill_first_write", f_first_fill, 2);
        check("refill_done", f_done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
